ga_generation_controller: RTL

//   Parametrised sequencer for the genetic-algorithm engine. It runs the init -> (selection -> mutation)^N

---
 rtl/ga_generation_controller.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/ga_generation_controller.sv
// Generation sequencer for the GA engine: runs init -> (selection -> mutation)^N,
// owns the population register and guards every phase with a done-timeout watchdog.
module ga_generation_controller #(
  parameter int POP_SIZE = 50,
  parameter int CHROM_W  = 150,
  parameter int GEN_W    = 16,
  parameter int TIMEOUT  = 65535,
  localparam int POP_W   = POP_SIZE * CHROM_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [GEN_W-1:0] num_gens,
  input  logic [POP_W-1:0] init_pop,
  input  logic             init_done,
  output logic             init_start,
  input  logic             sel_done,
  output logic             sel_start,
  input  logic [POP_W-1:0] mut_pop,
  input  logic             mut_done,
  output logic             mut_start,
  output logic [POP_W-1:0] population,
  output logic [GEN_W-1:0] gen_count,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [2:0]       state_out
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_INIT = 3'd1;
  localparam logic [2:0] S_SEL  = 3'd2;
  localparam logic [2:0] S_MUT  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  localparam int TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TO_LIM = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  logic [2:0]       state, nxt;
  logic [GEN_W-1:0] target, gen_inc;
  logic [TW-1:0]    ph_cnt;
  logic             wd_hit, accept, ld_init, ld_mut;
  logic             go_init, go_sel, go_mut, go_done;

  assign gen_inc   = gen_count + 1'b1;
  // The phase counter sits at TO_LIM on the TIMEOUT-th cycle of a phase.
  assign wd_hit    = (TIMEOUT != 0) && (ph_cnt == TW'(TO_LIM));
  assign state_out = state;

  always_comb begin
    nxt     = state;
    accept  = 1'b0;
    ld_init = 1'b0;
    ld_mut  = 1'b0;
    go_init = 1'b0;
    go_sel  = 1'b0;
    go_mut  = 1'b0;
    go_done = 1'b0;
    case (state)
      S_IDLE, S_ERR: begin
        if (start) begin
          nxt     = S_INIT;
          accept  = 1'b1;
          go_init = 1'b1;
        end
      end
      // Priority in every busy phase: abort, then the matching done, then timeout.
      S_INIT: begin
        if (abort) nxt = S_IDLE;
        else if (init_done) begin
          ld_init = 1'b1;
          if (target == '0) nxt = S_DONE;
          else begin
            nxt    = S_SEL;
            go_sel = 1'b1;
          end
        end else if (wd_hit) nxt = S_ERR;
      end
      S_SEL: begin
        if (abort) nxt = S_IDLE;
        else if (sel_done) begin
          nxt    = S_MUT;
          go_mut = 1'b1;
        end else if (wd_hit) nxt = S_ERR;
      end
      S_MUT: begin
        if (abort) nxt = S_IDLE;
        else if (mut_done) begin
          ld_mut = 1'b1;
          if (gen_inc == target) nxt = S_DONE;
          else begin
            nxt    = S_SEL;
            go_sel = 1'b1;
          end
        end else if (wd_hit) nxt = S_ERR;
      end
      S_DONE: begin
        nxt     = S_IDLE;
        go_done = 1'b1;
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      target     <= '0;
      ph_cnt     <= '0;
      population <= '0;
      gen_count  <= '0;
      init_start <= 1'b0;
      sel_start  <= 1'b0;
      mut_start  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state      <= nxt;
      init_start <= go_init;
      sel_start  <= go_sel;
      mut_start  <= go_mut;
      done       <= go_done;
      busy       <= (nxt == S_INIT) || (nxt == S_SEL) || (nxt == S_MUT);
      if (nxt != state) ph_cnt <= '0;
      else if (busy)    ph_cnt <= ph_cnt + 1'b1;
      if (accept) begin
        target    <= num_gens;
        gen_count <= '0;
        error     <= 1'b0;
      end
      if (nxt == S_ERR && state != S_ERR) error <= 1'b1;
      if (ld_init) population <= init_pop;
      if (ld_mut) begin
        population <= mut_pop;
        gen_count  <= gen_inc;
      end
    end
  end

endmodule
